// File: rtl/vend_controller.sv
// Vending machine controller: collects coins into a 4-bit credit, vends one of
// four priced items, and returns change or a refund until it is acknowledged.
// Every output is a register; inputs only reach outputs through one clock edge.
module vend_controller #(
    parameter logic [3:0] PRICE0 = 4'd2,
    parameter logic [3:0] PRICE1 = 4'd3,
    parameter logic [3:0] PRICE2 = 4'd5,
    parameter logic [3:0] PRICE3 = 4'd7
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [3:0] coin_value,
    input  logic       choice_valid,
    input  logic [1:0] choice,
    input  logic       cancel,
    input  logic       change_ack,
    output logic [3:0] credit,
    output logic       dispense,
    output logic [1:0] item_out,
    output logic [3:0] change,
    output logic       change_valid,
    output logic       coin_reject,
    output logic       insufficient,
    output logic [1:0] state
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COLLECT  = 2'd1;
    localparam logic [1:0] DISPENSE = 2'd2;
    localparam logic [1:0] RETURN   = 2'd3;

    // Item selected in COLLECT and its price, held for the DISPENSE cycle
    logic [1:0] item_q;
    logic [3:0] price_q;

    logic [1:0] state_n;
    logic [3:0] credit_n, change_n, price_q_n;
    logic [1:0] item_out_n, item_q_n;
    logic       dispense_n, change_valid_n, coin_reject_n, insufficient_n;

    logic [3:0] sel_price;
    logic [4:0] coin_sum;
    logic       can_buy;

    always_comb begin
        case (choice)
            2'd0:    sel_price = PRICE0;
            2'd1:    sel_price = PRICE1;
            2'd2:    sel_price = PRICE2;
            default: sel_price = PRICE3;
        endcase
    end

    // Five-bit sum so an overflowing coin can be detected and refused
    assign coin_sum = {1'b0, credit} + {1'b0, coin_value};
    assign can_buy  = (credit >= sel_price);

    // State and output registers, cleared asynchronously
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            credit       <= 4'd0;
            change       <= 4'd0;
            item_out     <= 2'd0;
            dispense     <= 1'b0;
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            item_q       <= 2'd0;
            price_q      <= 4'd0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            change       <= change_n;
            item_out     <= item_out_n;
            dispense     <= dispense_n;
            change_valid <= change_valid_n;
            coin_reject  <= coin_reject_n;
            insufficient <= insufficient_n;
            item_q       <= item_q_n;
            price_q      <= price_q_n;
        end
    end

    // Next-state selection; cancel outranks choice, which outranks coins
    always_comb begin
        state_n = state;
        case (state)
            IDLE:
                if (coin_valid && coin_value != 4'd0) state_n = COLLECT;
            COLLECT:
                if (cancel)                      state_n = RETURN;
                else if (choice_valid && can_buy) state_n = DISPENSE;
            DISPENSE:
                state_n = (credit != price_q) ? RETURN : IDLE;
            default:
                if (change_ack) state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs; pulses default low every cycle
    always_comb begin
        credit_n       = credit;
        change_n       = change;
        change_valid_n = change_valid;
        item_out_n     = item_out;
        item_q_n       = item_q;
        price_q_n      = price_q;
        dispense_n     = 1'b0;
        coin_reject_n  = 1'b0;
        insufficient_n = 1'b0;
        case (state)
            IDLE: begin
                if (coin_valid && coin_value != 4'd0) credit_n = coin_value;
                if (choice_valid) insufficient_n = 1'b1;
            end
            COLLECT: begin
                if (cancel) begin
                    change_n       = credit;
                    change_valid_n = 1'b1;
                    credit_n       = 4'd0;
                    coin_reject_n  = coin_valid;
                end else if (choice_valid && can_buy) begin
                    item_q_n      = choice;
                    price_q_n     = sel_price;
                    coin_reject_n = coin_valid;
                end else begin
                    // A refused selection does not block a coin in the same cycle
                    if (choice_valid) insufficient_n = 1'b1;
                    if (coin_valid) begin
                        if (coin_sum <= 5'd15) credit_n = coin_sum[3:0];
                        else                   coin_reject_n = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                dispense_n     = 1'b1;
                item_out_n     = item_q;
                credit_n       = 4'd0;
                change_n       = credit - price_q;
                change_valid_n = (credit != price_q);
                coin_reject_n  = coin_valid;
            end
            default: begin
                coin_reject_n = coin_valid;
                if (change_ack) begin
                    change_n       = 4'd0;
                    change_valid_n = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with hand-computed expectations.
module tb_vend_controller;

    logic       Clock = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [3:0] coin_value = 4'd0;
    logic       choice_valid = 1'b0;
    logic [1:0] choice = 2'd0;
    logic       cancel = 1'b0;
    logic       change_ack = 1'b0;
    logic [3:0] credit;
    logic       dispense;
    logic [1:0] item_out;
    logic [3:0] change;
    logic       change_valid;
    logic       coin_reject;
    logic       insufficient;
    logic [1:0] state;

    int n_chk = 0;
    int n_fail = 0;

    vend_controller dut (
        .Clock(Clock), .reset(reset),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .choice_valid(choice_valid), .choice(choice),
        .cancel(cancel), .change_ack(change_ack),
        .credit(credit), .dispense(dispense), .item_out(item_out),
        .change(change), .change_valid(change_valid),
        .coin_reject(coin_reject), .insufficient(insufficient),
        .state(state)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1ns later with all strobes dropped
    task automatic step();
        @(posedge Clock);
        #1;
        coin_valid = 1'b0; choice_valid = 1'b0; cancel = 1'b0; change_ack = 1'b0;
    endtask

    task automatic coin(input logic [3:0] v);
        coin_valid = 1'b1; coin_value = v; step();
    endtask

    task automatic pick(input logic [1:0] c);
        choice_valid = 1'b1; choice = c; step();
    endtask

    initial begin
        #12;
        chk("rst_state", state, 0);
        chk("rst_credit", credit, 0);
        chk("rst_cv", change_valid, 0);
        @(negedge Clock);
        reset = 1'b0;

        // IDLE: zero coin, choice and stray ack
        coin(4'd0);
        chk("idle_zero_coin_state", state, 0);
        change_ack = 1'b1; pick(2'd0);
        chk("idle_insuff", insufficient, 1);
        chk("idle_ack_cv", change_valid, 0);
        chk("idle_state", state, 0);

        // coins 2,1 then item 1 (price 3), exact
        coin(4'd2);
        chk("t1_credit2", credit, 2);
        chk("t1_collect", state, 1);
        coin(4'd1);
        chk("t1_credit3", credit, 3);
        pick(2'd1);
        chk("t1_disp_state", state, 2);
        chk("t1_no_disp_yet", dispense, 0);
        step();
        chk("t1_dispense", dispense, 1);
        chk("t1_item", item_out, 1);
        chk("t1_change", change, 0);
        chk("t1_cv", change_valid, 0);
        chk("t1_credit0", credit, 0);
        chk("t1_idle", state, 0);
        step();
        chk("t1_disp_pulse", dispense, 0);

        // coins 5,4 then item 3 (price 7) -> change 2
        coin(4'd5); coin(4'd4);
        chk("t2_credit9", credit, 9);
        pick(2'd3);
        step();
        chk("t2_dispense", dispense, 1);
        chk("t2_item", item_out, 3);
        chk("t2_change", change, 2);
        chk("t2_cv", change_valid, 1);
        chk("t2_return", state, 3);
        step();
        chk("t2_hold_change", change, 2);
        chk("t2_hold_cv", change_valid, 1);
        chk("t2_disp_low", dispense, 0);
        change_ack = 1'b1; step();
        chk("t2_ack_cv", change_valid, 0);
        chk("t2_ack_change", change, 0);
        chk("t2_idle", state, 0);

        // overflow refusal at 12+4, then 12+3 = 15
        coin(4'd5); coin(4'd7);
        chk("t3_credit12", credit, 12);
        coin(4'd4);
        chk("t3_reject", coin_reject, 1);
        chk("t3_credit_kept", credit, 12);
        step();
        chk("t3_reject_pulse", coin_reject, 0);
        coin(4'd3);
        chk("t3_credit15", credit, 15);
        cancel = 1'b1; step();
        chk("t3_refund", change, 15);
        change_ack = 1'b1; step();

        // insufficient credit then cancel
        coin(4'd3);
        pick(2'd2);
        chk("t4_insuff", insufficient, 1);
        chk("t4_collect", state, 1);
        chk("t4_credit3", credit, 3);
        step();
        chk("t4_insuff_pulse", insufficient, 0);
        cancel = 1'b1; step();
        chk("t4_change", change, 3);
        chk("t4_cv", change_valid, 1);
        chk("t4_return", state, 3);
        chk("t4_credit0", credit, 0);
        change_ack = 1'b1; step();

        // simultaneous cancel, choice and coin at credit 6
        coin(4'd6);
        cancel = 1'b1; choice_valid = 1'b1; choice = 2'd0;
        coin_valid = 1'b1; coin_value = 4'd1;
        step();
        chk("t5_refund", change, 6);
        chk("t5_cv", change_valid, 1);
        chk("t5_reject", coin_reject, 1);
        chk("t5_state", state, 3);
        step();
        chk("t5_no_disp", dispense, 0);
        coin(4'd2);
        chk("t5_return_reject", coin_reject, 1);
        change_ack = 1'b1; step();

        // reset between edges while refunding 9
        coin(4'd5); coin(4'd4);
        cancel = 1'b1; step();
        chk("t6_change9", change, 9);
        #2 reset = 1'b1;
        #1;
        chk("t6_state", state, 0);
        chk("t6_credit", credit, 0);
        chk("t6_change", change, 0);
        chk("t6_cv", change_valid, 0);
        chk("t6_item", item_out, 0);
        #1 reset = 1'b0;
        step();
        chk("t6_cv_after", change_valid, 0);
        chk("t6_idle_after", state, 0);
        chk("t6_disp_after", dispense, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameters SHALL be as follows; each price SHALL be in the range 1..15:
- PRICE0, default 4'd2, price of item 0.
- PRICE1, default 4'd3, price of item 1.
- PRICE2, default 4'd5, price of item 2.
- PRICE3, default 4'd7, price of item 3.

REQ-002 Ports SHALL be as follows:
- Clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- coin_valid  input  1  one-cycle coin-inserted strobe.
- coin_value  input  4  coin value, sampled when coin_valid=1.
- choice_valid  input  1  one-cycle selection strobe.
- choice  input  2  item index, sampled when choice_valid=1.
- cancel  input  1  one-cycle refund request.
- change_ack  input  1  change-collected acknowledge.
- credit  output  4  current accumulated credit; the display value.
- dispense  output  1  one-cycle vend pulse.
- item_out  output  2  vended item index, valid with dispense.
- change  output  4  change or refund amount, valid with change_valid.
- change_valid  output  1  change is pending.
- coin_reject  output  1  one-cycle pulse: coin not accepted.
- insufficient  output  1  one-cycle pulse: selection refused.
- state  output  2  FSM state encoding.

REQ-003 All outputs SHALL be registered, with no combinational input-to-output path.

Function
REQ-004 FSM states SHALL be IDLE=0, COLLECT=1, DISPENSE=2, RETURN=3.
REQ-005 All input strobes SHALL be sampled on the rising Clock edge; every response SHALL appear on the outputs one cycle later.
REQ-006 IDLE transitions SHALL be:
- coin_valid with coin_value!=0 -> credit=coin_value, go to COLLECT.
- coin_value=0 -> ignored.
- choice_valid -> insufficient pulse, stay in IDLE.
- cancel -> ignored.
REQ-007 COLLECT, coin_valid: if credit+coin_value<=15 (5-bit sum), credit SHALL add coin_value; otherwise coin_reject SHALL pulse and credit SHALL remain unchanged.
REQ-008 COLLECT, choice_valid with credit>=PRICE[choice]: latch choice and price, go to DISPENSE.
REQ-009 COLLECT, choice_valid with credit<PRICE[choice]: insufficient SHALL pulse, stay in COLLECT.
REQ-010 COLLECT, cancel: change=credit, credit=0, change_valid=1, go to RETURN.
REQ-011 Simultaneous strobes in COLLECT SHALL be prioritised cancel > choice_valid > coin_valid.
- A lower-priority choice is dropped silently.
- A coin arriving alongside an accepted cancel or choice SHALL get coin_reject and SHALL NOT be credited.
REQ-012 DISPENSE SHALL last exactly one cycle, and the next register update SHALL set dispense=1, item_out=latched item and credit=0.
REQ-013 DISPENSE exit: if credit-price!=0, set change=credit-price and change_valid=1, go to RETURN; else go to IDLE with change=0.
REQ-014 RETURN SHALL hold change and change_valid stable until change_ack=1 is sampled, then clear both and go to IDLE.
REQ-015 A change_ack sampled in any state other than RETURN SHALL be ignored.
REQ-016 In DISPENSE and RETURN, coin_valid SHALL produce coin_reject; choice_valid and cancel SHALL be ignored.
REQ-017 Credit arithmetic SHALL be unsigned 4-bit; credit SHALL never wrap, since overflow is prevented by REQ-007.
REQ-018 Change SHALL equal credit-price, with no underflow because of the check in REQ-008.
REQ-019 dispense, coin_reject and insufficient SHALL be single-cycle pulses that are low in every other cycle.

Reset
REQ-020 When reset=1, all of the following SHALL take effect asynchronously without waiting for a Clock edge:
- state=IDLE.
- credit=0, change=0, item_out=0.
- dispense=0, change_valid=0, coin_reject=0, insufficient=0.
REQ-021 Reset asserted mid-transaction SHALL discard any credit and any pending change, with no dispense or refund.
REQ-022 The first edge after reset deasserts SHALL behave as IDLE.

Verification
REQ-023 Bench SHALL cover: coins 2,1 then choice=1 -> credit 2,3; dispense=1, item_out=1; change 0; state returns to IDLE.
REQ-024 Bench SHALL cover: coins 5,4 then choice=3 -> dispense with item_out=3; change=2 with change_valid held until change_ack; then IDLE.
REQ-025 Bench SHALL cover: credit 12, coin 4 -> coin_reject pulse, credit stays 12; then coin 3 -> credit 15.
REQ-026 Bench SHALL cover: credit 3, choice=2 -> insufficient pulse, stay in COLLECT with credit 3; then cancel -> change=3 in RETURN.
REQ-027 Bench SHALL cover: credit 6, cancel+choice_valid+coin_valid in the same cycle -> refund 6, no dispense, coin_reject=1.
REQ-028 Bench SHALL cover: credit 9 in RETURN, reset pulse between edges -> all outputs 0 immediately, state=IDLE, no change_valid after release.
